// File: rtl/pika_regfile_if.sv
// pika_regfile_if: pipeline-side bundle for the PikaRISC register file (fetch, execute, issue, writeback).
interface pika_regfile_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 16,
    parameter int NRD   = 3
);
    localparam int AW = $clog2(NREGS);
    logic [XLEN-1:0]     if_pc_out;
    logic [XLEN-1:0]     if_pc_in;
    logic                if_pc_write_en;
    logic [NRD*AW-1:0]   exe_rd_num;
    logic [NRD*XLEN-1:0] exe_rd_data;
    logic [NRD-1:0]      exe_rd_valid_mask;
    logic [XLEN-1:0]     exe_cpsr_out;
    logic                exe_hazard;
    logic                iss_en;
    logic [AW-1:0]       iss_rd_num;
    logic [AW-1:0]       wb_rd_num;
    logic                wb_rd_write_en;
    logic [XLEN-1:0]     wb_rd_in;
    logic                wb_pc_write_en;
    logic [XLEN-1:0]     wb_pc_in;
    logic                wb_cpsr_write_en;
    logic [XLEN-1:0]     wb_cpsr_in;
    logic [AW:0]         pending_cnt;

    modport master (
        input  if_pc_out, exe_rd_data, exe_cpsr_out, exe_hazard, pending_cnt,
        output if_pc_in, if_pc_write_en, exe_rd_num, exe_rd_valid_mask, iss_en, iss_rd_num,
               wb_rd_num, wb_rd_write_en, wb_rd_in, wb_pc_write_en, wb_pc_in,
               wb_cpsr_write_en, wb_cpsr_in
    );
    modport slave (
        output if_pc_out, exe_rd_data, exe_cpsr_out, exe_hazard, pending_cnt,
        input  if_pc_in, if_pc_write_en, exe_rd_num, exe_rd_valid_mask, iss_en, iss_rd_num,
               wb_rd_num, wb_rd_write_en, wb_rd_in, wb_pc_write_en, wb_pc_in,
               wb_cpsr_write_en, wb_cpsr_in
    );
endinterface

// File: rtl/pika_regfile.sv
// pika_regfile: GPRs, PC and CPSR with a pending-write scoreboard for RAW stalls.
// Define PIKA_RF_BYPASS_EN to forward same-cycle writeback data to the read ports and CPSR.
module pika_regfile #(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 16,
    parameter int              NRD      = 3,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic           clk,
    input logic           reset,
    pika_regfile_if.slave rf
);
    localparam int AW = $clog2(NREGS);
`ifdef PIKA_RF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [XLEN-1:0]  gpr_q [NREGS];
    logic [XLEN-1:0]  pc_q, pc_d, cpsr_q, cpsr_d;
    logic [NREGS-1:0] pend_q, pend_d;
    logic [NRD-1:0]   hz;
    logic [AW:0]      cnt;

    always_comb begin
        pc_d   = rf.wb_pc_write_en ? rf.wb_pc_in : rf.if_pc_write_en ? rf.if_pc_in : pc_q;
        cpsr_d = rf.wb_cpsr_write_en ? rf.wb_cpsr_in : cpsr_q;
        // set is applied after clear so a same-register issue stays outstanding
        pend_d = (pend_q & ~(NREGS'(rf.wb_rd_write_en) << rf.wb_rd_num))
               | (NREGS'(rf.iss_en) << rf.iss_rd_num);
        cnt    = '0;
        for (int i = 0; i < NREGS; i++) cnt += (AW+1)'(pend_q[i]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) gpr_q[i] <= '0;
            pc_q   <= RESET_PC;
            cpsr_q <= '0;
            pend_q <= '0;
        end else begin
            if (rf.wb_rd_write_en) gpr_q[rf.wb_rd_num] <= rf.wb_rd_in;
            pc_q   <= pc_d;
            cpsr_q <= cpsr_d;
            pend_q <= pend_d;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] num;
        logic          byp;
        assign num = rf.exe_rd_num[k*AW +: AW];
        assign byp = BYPASS && rf.wb_rd_write_en && (rf.wb_rd_num == num);
        assign rf.exe_rd_data[k*XLEN +: XLEN] = byp ? rf.wb_rd_in : gpr_q[num];
        assign hz[k] = rf.exe_rd_valid_mask[k] && pend_q[num] && !byp;
    end

    assign rf.if_pc_out    = pc_q;
    assign rf.exe_cpsr_out = (BYPASS && rf.wb_cpsr_write_en) ? rf.wb_cpsr_in : cpsr_q;
    assign rf.exe_hazard   = |hz;
    assign rf.pending_cnt  = cnt;
endmodule
